// File: rtl/sb_spi_pkg.sv
// sb_spi_pkg: register map, status/control bit positions and sequencer states
// shared by the system-bus SPI initiator.
package sb_spi_pkg;
    localparam logic [3:0] OFF_CR1  = 4'h9;
    localparam logic [3:0] OFF_CR2  = 4'hA;
    localparam logic [3:0] OFF_BR   = 4'hB;
    localparam logic [3:0] OFF_SR   = 4'hC;
    localparam logic [3:0] OFF_TXDR = 4'hD;
    localparam logic [3:0] OFF_RXDR = 4'hE;
    localparam logic [3:0] OFF_CSR  = 4'hF;
    localparam int SR_TIP  = 7;
    localparam int SR_BUSY = 6;
    localparam int SR_TRDY = 4;
    localparam int SR_RRDY = 3;
    localparam int CR2_MSTR = 7;
    localparam int CR2_MCSH = 6;
    localparam int CR2_MODE = 1;
    localparam logic [7:0] CR1_SPE    = 8'h80;
    localparam logic [7:0] CSR_ALL_HI = 8'h0F;
    localparam logic [7:0] CSR_CS0_LO = 8'h0E;
    typedef enum logic [3:0] {
        INIT_CR1, INIT_CR2, INIT_BR, INIT_CSR, IDLE, CS_LO,
        POLL_T, WR_TX, POLL_R, RD_RX, CS_HI, ERROR
    } state_t;
    function automatic logic [7:0] cr2_val(input logic [1:0] mode);
        return 8'((1 << CR2_MSTR) | (1 << CR2_MCSH) | (int'(mode) << CR2_MODE));
    endfunction
    function automatic logic sr_bit(input logic [7:0] sr, input int idx);
        return |(sr & 8'(1 << idx));
    endfunction
endpackage

// File: rtl/sb_bus_cycle.sv
// sb_bus_cycle: one system-bus transaction; owns the strobe, holds the bus
// stable until acknowledge and gives up after ACK_TIMEOUT strobe cycles.
module sb_bus_cycle #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] adr,
    input  logic [7:0] wdata,
    output logic       done,
    output logic [7:0] rdata,
    output logic       timeout,
    output logic [7:0] sb_adr,
    output logic [7:0] sb_dat_o,
    output logic       sb_rw,
    output logic       sb_stb,
    input  logic [7:0] sb_dat_i,
    input  logic       sb_ack
);
    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(ACK_TIMEOUT - 1);
    logic [CW-1:0] cnt;
    // done/timeout pulse while the strobe is low, which provides the idle gap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_stb   <= 1'b0;
            sb_rw    <= 1'b0;
            sb_adr   <= '0;
            sb_dat_o <= '0;
            rdata    <= '0;
            done     <= 1'b0;
            timeout  <= 1'b0;
            cnt      <= '0;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            if (sb_stb) begin
                if (sb_ack) begin
                    sb_stb <= 1'b0;
                    done   <= 1'b1;
                    if (!sb_rw) rdata <= sb_dat_i;
                end else if (cnt == LAST) begin
                    sb_stb  <= 1'b0;
                    timeout <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (start) begin
                sb_stb   <= 1'b1;
                sb_rw    <= rw;
                sb_adr   <= adr;
                sb_dat_o <= wdata;
                cnt      <= '0;
            end
        end
    end
endmodule

// File: rtl/sb_spi_initiator.sv
// sb_spi_initiator: sequences SPI hard-IP register accesses to turn a
// valid/ready byte stream into complete SPI master transfers.
module sb_spi_initiator import sb_spi_pkg::*; #(
    parameter logic [3:0] BUS_ADDR74  = 4'b0000,
    parameter logic [5:0] CLK_DIV     = 6'd7,
    parameter logic [1:0] CPOL_CPHA   = 2'b00,
    parameter int         ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       cs_hold,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       bus_err,
    output logic [7:0] sb_adr,
    output logic [7:0] sb_dat_o,
    output logic       sb_rw,
    output logic       sb_stb,
    input  logic [7:0] sb_dat_i,
    input  logic       sb_ack
);
    state_t state, next, adv;
    logic pend, start, rw, done, timeout, hold_q, cs_low, rx_hit;
    logic [3:0] off;
    logic [7:0] wdata, rdata, txb;

    sb_bus_cycle #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_bus (
        .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .adr({BUS_ADDR74, off}),
        .wdata(wdata), .done(done), .rdata(rdata), .timeout(timeout),
        .sb_adr(sb_adr), .sb_dat_o(sb_dat_o), .sb_rw(sb_rw), .sb_stb(sb_stb),
        .sb_dat_i(sb_dat_i), .sb_ack(sb_ack)
    );

    always_comb begin
        adv   = state;
        rw    = 1'b1;
        off   = OFF_CSR;
        wdata = CSR_ALL_HI;
        case (state)
            INIT_CR1: begin off = OFF_CR1;  wdata = CR1_SPE;             adv = INIT_CR2; end
            INIT_CR2: begin off = OFF_CR2;  wdata = cr2_val(CPOL_CPHA);  adv = INIT_BR;  end
            INIT_BR:  begin off = OFF_BR;   wdata = {2'b00, CLK_DIV};    adv = INIT_CSR; end
            INIT_CSR: adv = IDLE;
            CS_LO:    begin wdata = CSR_CS0_LO; adv = POLL_T; end
            POLL_T:   begin off = OFF_SR;   rw = 1'b0; adv = sr_bit(rdata, SR_TRDY) ? WR_TX : POLL_T; end
            WR_TX:    begin off = OFF_TXDR; wdata = txb; adv = POLL_R; end
            POLL_R:   begin off = OFF_SR;   rw = 1'b0; adv = sr_bit(rdata, SR_RRDY) ? RD_RX : POLL_R; end
            RD_RX:    begin off = OFF_RXDR; rw = 1'b0; adv = hold_q ? IDLE : CS_HI; end
            CS_HI:    adv = IDLE;
            default:  ;
        endcase
        tx_ready = state == IDLE;
        start    = !pend && state != IDLE && state != ERROR;
        rx_hit   = state == RD_RX && sb_stb && sb_ack;
        next     = timeout ? ERROR : done ? adv :
                   (tx_ready && tx_valid) ? (cs_low ? POLL_T : CS_LO) : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT_CR1;
            pend     <= 1'b0;
            txb      <= '0;
            hold_q   <= 1'b0;
            cs_low   <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            bus_err  <= 1'b0;
        end else begin
            state    <= next;
            pend     <= (done || timeout) ? 1'b0 : (pend || start);
            rx_valid <= rx_hit;
            if (rx_hit) rx_data <= sb_dat_i;
            if (tx_ready && tx_valid) begin
                txb    <= tx_data;
                hold_q <= cs_hold;
            end
            if (done && state == CS_LO) cs_low <= 1'b1;
            if (done && state == CS_HI) cs_low <= 1'b0;
            if (timeout) bus_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sb_spi_initiator.sv
// tb_sb_spi_initiator: randomized bench with a loopback SB responder and a
// transaction-level model of the expected register access sequence.
module tb_sb_spi_initiator;
    logic clk = 1'b0, rst_n = 1'b0, tx_valid = 1'b0, cs_hold = 1'b0, sb_ack = 1'b0;
    logic [7:0] tx_data = '0, sb_dat_i = '0;
    logic tx_ready, rx_valid, bus_err, sb_rw, sb_stb;
    logic [7:0] rx_data, sb_adr, sb_dat_o;
    int vec = 0, bad = 0;
    int ack_dly = 0, wait_cnt = 0, sr_stall = 0, rx_cnt = 0;
    bit noack = 1'b0, cs_low_m = 1'b0;
    logic [7:0] txreg = '0;
    logic [16:0] log_q[$], exp_q[$];
    logic [7:0] rx_q[$], exp_rx[$];

    always #5 clk = ~clk;

    sb_spi_initiator dut (
        .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .cs_hold(cs_hold), .rx_valid(rx_valid), .rx_data(rx_data), .bus_err(bus_err),
        .sb_adr(sb_adr), .sb_dat_o(sb_dat_o), .sb_rw(sb_rw), .sb_stb(sb_stb),
        .sb_dat_i(sb_dat_i), .sb_ack(sb_ack)
    );

    // Responder: acks ack_dly cycles into a strobe; SR reads stall TRDY, RXDR echoes TXDR
    always @(negedge clk) begin
        if (rx_valid) begin
            rx_q.push_back(rx_data);
            rx_cnt++;
        end
        if (sb_stb && !sb_ack && !noack && wait_cnt >= ack_dly) begin
            sb_ack = 1'b1;
            if (!sb_rw) sb_dat_i = (sb_adr == 8'h0E) ? txreg : (sb_adr == 8'h0C) ? ((sr_stall > 0) ? 8'h00 : 8'h18) : 8'hEE;
            if (!sb_rw && sb_adr == 8'h0C && sr_stall > 0) sr_stall--;
            if (sb_rw && sb_adr == 8'h0D) txreg = sb_dat_o;
            log_q.push_back({sb_rw, sb_adr, sb_rw ? sb_dat_o : sb_dat_i});
        end else begin
            wait_cnt = (sb_stb && !sb_ack) ? wait_cnt + 1 : 0;
            sb_ack = 1'b0;
        end
    end

    function automatic void exp_init();
        exp_q.push_back({1'b1, 8'h09, 8'h80});
        exp_q.push_back({1'b1, 8'h0A, 8'hC0});
        exp_q.push_back({1'b1, 8'h0B, 8'h07});
        exp_q.push_back({1'b1, 8'h0F, 8'h0F});
    endfunction

    function automatic void exp_byte(input logic [7:0] b, input bit hold, input int stall);
        if (!cs_low_m) begin
            exp_q.push_back({1'b1, 8'h0F, 8'h0E});
            cs_low_m = 1'b1;
        end
        for (int i = 0; i < stall; i++) exp_q.push_back({1'b0, 8'h0C, 8'h00});
        exp_q.push_back({1'b0, 8'h0C, 8'h18});
        exp_q.push_back({1'b1, 8'h0D, b});
        exp_q.push_back({1'b0, 8'h0C, 8'h18});
        exp_q.push_back({1'b0, 8'h0E, b});
        exp_rx.push_back(b);
        if (!hold) begin
            exp_q.push_back({1'b1, 8'h0F, 8'h0F});
            cs_low_m = 1'b0;
        end
    endfunction

    task automatic clear_q();
        log_q.delete();
        exp_q.delete();
        rx_q.delete();
        exp_rx.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        clear_q();
        cs_low_m = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (!tx_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        vec++;
        if (tx_ready !== 1'b1) begin bad++; $display("FAIL %s_idle: tx_ready=%b want 1", nm, tx_ready); end
    endtask

    task automatic send(input logic [7:0] b, input bit hold);
        int n = 0;
        int c = rx_cnt;
        wait_idle("send");
        tx_valid = 1'b1;
        tx_data  = b;
        cs_hold  = hold;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        vec++;
        if (tx_ready !== 1'b0) begin bad++; $display("FAIL send_busy: tx_ready=%b want 0", tx_ready); end
        while (rx_cnt == c && n < 600) begin
            @(negedge clk);
            n++;
        end
        vec++;
        if (rx_cnt == c) begin bad++; $display("FAIL send_rx: rx pulses=%0d want %0d", rx_cnt - c, 1); end
    endtask

    task automatic test_reset();
        noack = 1'b0;
        ack_dly = 0;
        do_reset();
        vec++;
        if ({tx_ready, rx_valid, rx_data, bus_err, sb_adr, sb_dat_o, sb_rw, sb_stb} !== 28'h0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", {tx_ready, rx_valid, rx_data, bus_err, sb_adr, sb_dat_o, sb_rw, sb_stb});
        end
        exp_init();
        rst_n = 1'b1;
        wait_idle("init");
        vec++;
        if (log_q.size() != exp_q.size()) begin bad++; $display("FAIL init_log_len: got %0d want %0d", log_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < log_q.size()) begin
            vec++;
            if (log_q[i] !== exp_q[i]) begin bad++; $display("FAIL init_log[%0d]: got %h want %h", i, log_q[i], exp_q[i]); end
        end
        vec++;
        if (bus_err !== 1'b0) begin bad++; $display("FAIL init_err: bus_err=%b want 0", bus_err); end
    endtask

    task automatic test_hold_during_init();
        int n = 0;
        do_reset();
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        cs_hold  = 1'b0;
        exp_init();
        exp_byte(8'h3C, 1'b0, 0);
        rst_n = 1'b1;
        while (rx_cnt == 0 + rx_cnt - rx_q.size() && rx_q.size() == 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        tx_valid = 1'b0;
        wait_idle("early");
        vec++;
        if (log_q.size() != exp_q.size()) begin bad++; $display("FAIL early_log_len: got %0d want %0d", log_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < log_q.size()) begin
            vec++;
            if (log_q[i] !== exp_q[i]) begin bad++; $display("FAIL early_log[%0d]: got %h want %h", i, log_q[i], exp_q[i]); end
        end
        vec++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h3C) begin bad++; $display("FAIL early_rx: got %0d bytes want 1 byte 3c", rx_q.size()); end
    endtask

    task automatic test_loopback();
        clear_q();
        sr_stall = 0;
        exp_byte(8'hA5, 1'b0, 0);
        send(8'hA5, 1'b0);
        wait_idle("loop");
        vec++;
        if (log_q.size() != exp_q.size()) begin bad++; $display("FAIL loop_log_len: got %0d want %0d", log_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < log_q.size()) begin
            vec++;
            if (log_q[i] !== exp_q[i]) begin bad++; $display("FAIL loop_log[%0d]: got %h want %h", i, log_q[i], exp_q[i]); end
        end
        vec++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin bad++; $display("FAIL loop_rx: got %0d bytes want 1 byte a5", rx_q.size()); end
    endtask

    task automatic test_cs_hold();
        int lo = 0, hi = 0;
        clear_q();
        exp_byte(8'h12, 1'b1, 0);
        exp_byte(8'h34, 1'b0, 0);
        send(8'h12, 1'b1);
        send(8'h34, 1'b0);
        wait_idle("hold");
        foreach (log_q[i]) begin
            if (log_q[i] == {1'b1, 8'h0F, 8'h0E}) lo++;
            if (log_q[i] == {1'b1, 8'h0F, 8'h0F}) hi++;
        end
        vec++;
        if (lo != 1 || hi != 1) begin bad++; $display("FAIL hold_csr: got lo=%0d hi=%0d want 1 1", lo, hi); end
        vec++;
        if (log_q.size() != exp_q.size()) begin bad++; $display("FAIL hold_log_len: got %0d want %0d", log_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < log_q.size()) begin
            vec++;
            if (log_q[i] !== exp_q[i]) begin bad++; $display("FAIL hold_log[%0d]: got %h want %h", i, log_q[i], exp_q[i]); end
        end
        foreach (exp_rx[i]) begin
            vec++;
            if (i >= rx_q.size() || rx_q[i] !== exp_rx[i]) begin bad++; $display("FAIL hold_rx[%0d]: got %0d bytes want %h", i, rx_q.size(), exp_rx[i]); end
        end
    endtask

    task automatic test_stall();
        int sr = 0;
        bit seen = 1'b0;
        clear_q();
        sr_stall = 10;
        exp_byte(8'h5C, 1'b0, 10);
        send(8'h5C, 1'b0);
        wait_idle("stall");
        foreach (log_q[i]) begin
            if (log_q[i][16:8] == {1'b1, 8'h0D}) seen = 1'b1;
            if (!seen && log_q[i][16:8] == {1'b0, 8'h0C}) sr++;
        end
        vec++;
        if (sr != 11) begin bad++; $display("FAIL stall_sr_reads: got %0d want 11", sr); end
        vec++;
        if (bus_err !== 1'b0) begin bad++; $display("FAIL stall_err: bus_err=%b want 0", bus_err); end
        vec++;
        if (log_q.size() != exp_q.size()) begin bad++; $display("FAIL stall_log_len: got %0d want %0d", log_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < log_q.size()) begin
            vec++;
            if (log_q[i] !== exp_q[i]) begin bad++; $display("FAIL stall_log[%0d]: got %h want %h", i, log_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        clear_q();
        for (int k = 0; k < 12; k++) begin
            logic [7:0] b = 8'($urandom);
            bit hold = (k == 11) ? 1'b0 : 1'($urandom_range(0, 1));
            int stall = int'($urandom_range(0, 3));
            wait_idle("rand");
            ack_dly = int'($urandom_range(0, 3));
            sr_stall = stall;
            exp_byte(b, hold, stall);
            send(b, hold);
        end
        wait_idle("rand");
        ack_dly = 0;
        vec++;
        if (log_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_log_len: got %0d want %0d", log_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < log_q.size()) begin
            vec++;
            if (log_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_log[%0d]: got %h want %h", i, log_q[i], exp_q[i]); end
        end
        foreach (exp_rx[i]) begin
            vec++;
            if (i >= rx_q.size() || rx_q[i] !== exp_rx[i]) begin bad++; $display("FAIL rand_rx[%0d]: got %0d bytes want %h", i, rx_q.size(), exp_rx[i]); end
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        bit ok = 1'b1;
        noack = 1'b1;
        do_reset();
        rst_n = 1'b1;
        while (!sb_stb && n < 30) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (sb_stb && n < 100) begin
            n++;
            @(negedge clk);
        end
        vec++;
        if (n != 16) begin bad++; $display("FAIL timeout_stb_len: got %0d want 16", n); end
        repeat (3) @(negedge clk);
        vec++;
        if (bus_err !== 1'b1 || tx_ready !== 1'b0) begin bad++; $display("FAIL timeout_err: bus_err=%b tx_ready=%b want 1 0", bus_err, tx_ready); end
        tx_valid = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (sb_stb || tx_ready || !bus_err) ok = 1'b0;
        end
        tx_valid = 1'b0;
        vec++;
        if (!ok) begin bad++; $display("FAIL timeout_sticky: stb=%b ready=%b err=%b want 0 0 1", sb_stb, tx_ready, bus_err); end
        #1 rst_n = 1'b0;
        #1;
        vec++;
        if (bus_err !== 1'b0) begin bad++; $display("FAIL timeout_clear: bus_err=%b want 0", bus_err); end
        noack = 1'b0;
        do_reset();
        exp_init();
        rst_n = 1'b1;
        wait_idle("retry");
        vec++;
        if (log_q.size() != exp_q.size()) begin bad++; $display("FAIL retry_log_len: got %0d want %0d", log_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < log_q.size()) begin
            vec++;
            if (log_q[i] !== exp_q[i]) begin bad++; $display("FAIL retry_log[%0d]: got %h want %h", i, log_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int c;
        wait_idle("mid");
        c = rx_cnt;
        ack_dly = 5;
        tx_valid = 1'b1;
        tx_data  = 8'h5A;
        cs_hold  = 1'b0;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        while (!(sb_stb && sb_adr == 8'h0D) && n < 300) begin
            @(negedge clk);
            n++;
        end
        vec++;
        if (!(sb_stb && sb_adr == 8'h0D)) begin bad++; $display("FAIL mid_reach: stb=%b adr=%h want 1 0d", sb_stb, sb_adr); end
        #1 rst_n = 1'b0;
        #1;
        vec++;
        if ({sb_stb, sb_rw, sb_adr, sb_dat_o} !== 18'h0) begin bad++; $display("FAIL mid_stb: got %h want 0", {sb_stb, sb_rw, sb_adr, sb_dat_o}); end
        ack_dly = 0;
        do_reset();
        exp_init();
        rst_n = 1'b1;
        wait_idle("mid_init");
        vec++;
        if (rx_cnt != c) begin bad++; $display("FAIL mid_rx: pulses=%0d want 0", rx_cnt - c); end
        vec++;
        if (log_q.size() != exp_q.size()) begin bad++; $display("FAIL mid_log_len: got %0d want %0d", log_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < log_q.size()) begin
            vec++;
            if (log_q[i] !== exp_q[i]) begin bad++; $display("FAIL mid_log[%0d]: got %h want %h", i, log_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_hold_during_init();
        test_loopback();
        test_cs_hold();
        test_stall();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
